// File: rtl/mem_port_arbiter.sv
// Two-requester (core, program loader) arbiter for one synchronous memory port.
// One access in flight: IDLE arbitrates, ACCESS drives the memory, RESP returns the result.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_ready,
  output logic        c_err,
  output logic        c_gnt,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic [31:0] l_rdata,
  output logic        l_ready,
  output logic        l_err,
  output logic        l_gnt,
  output logic        core_stall,
  output logic        m_en,
  output logic        m_we,
  output logic [29:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  // Handshake: a requester raises req with we/addr/wdata and holds them until its
  // ready pulses for one cycle; fields are latched when req is sampled in IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_win;   // 0 = core, 1 = loader
  logic        r_last;  // last granted requester, same encoding
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_any;
  logic        w_pick_l;
  logic        w_mis;
  logic        w_access;
  logic        w_resp;
  logic [31:0] w_rd;

  assign w_any    = c_req | l_req;
  // On a tie the requester that was not granted last wins.
  assign w_pick_l = l_req & (~c_req | ~r_last);
  assign w_mis    = |r_addr[1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_win   <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_win   <= w_pick_l;
        r_we    <= w_pick_l ? l_we    : c_we;
        r_addr  <= w_pick_l ? l_addr  : c_addr;
        r_wdata <= w_pick_l ? l_wdata : c_wdata;
      end
      if (r_state == RESP) r_last <= r_win;
    end
  end

  // Outputs are decoded from registered state; reset blanks them while it is held.
  always_comb begin
    w_access   = (r_state == ACCESS) & ~reset;
    w_resp     = (r_state == RESP) & ~reset;
    w_rd       = (w_resp & ~r_we & ~w_mis) ? m_rdata : 32'd0;
    m_en       = w_access & ~w_mis;
    m_we       = w_access & ~w_mis & r_we;
    m_addr     = w_access ? r_addr[31:2] : 30'd0;
    m_wdata    = w_access ? r_wdata : 32'd0;
    c_gnt      = (w_access | w_resp) & ~r_win;
    l_gnt      = (w_access | w_resp) & r_win;
    c_ready    = w_resp & ~r_win;
    l_ready    = w_resp & r_win;
    c_err      = w_resp & ~r_win & w_mis;
    l_err      = w_resp & r_win & w_mis;
    c_rdata    = r_win ? 32'd0 : w_rd;
    l_rdata    = r_win ? w_rd : 32'd0;
    core_stall = c_req & ~c_ready;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table driven through a scoreboard,
// plus hand-written tie, reset-in-access and dropped-request sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, c_ready, c_err, c_gnt;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        l_req, l_we, l_ready, l_err, l_gnt;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        core_stall, m_en, m_we;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'd0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .c_req      (c_req),
    .c_we       (c_we),
    .c_addr     (c_addr),
    .c_wdata    (c_wdata),
    .c_rdata    (c_rdata),
    .c_ready    (c_ready),
    .c_err      (c_err),
    .c_gnt      (c_gnt),
    .l_req      (l_req),
    .l_we       (l_we),
    .l_addr     (l_addr),
    .l_wdata    (l_wdata),
    .l_rdata    (l_rdata),
    .l_ready    (l_ready),
    .l_err      (l_err),
    .l_gnt      (l_gnt),
    .core_stall (core_stall),
    .m_en       (m_en),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata)
  );

  logic [133:0] all_out;
  assign all_out = {c_rdata, c_ready, c_err, c_gnt, l_rdata, l_ready, l_err, l_gnt,
                    m_en, m_we, m_addr, m_wdata};

  // Memory model: unwritten words return a fixed pattern (word 4 reads 0xDEADBEEF);
  // read data is registered and garbage whenever the port is not enabled.
  logic [31:0]  mem [0:255];
  logic [255:0] wr_valid = '0;

  function automatic logic [31:0] pat(input logic [29:0] a);
    return 32'hDEADBEEF ^ {a ^ 30'd4, 2'b00};
  endfunction

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        mem[m_addr[7:0]]      <= m_wdata;
        wr_valid[m_addr[7:0]] <= 1'b1;
      end
      m_rdata <= wr_valid[m_addr[7:0]] ? mem[m_addr[7:0]] : pat(m_addr);
    end else begin
      m_rdata <= 32'hBAD0BAD0;
    end
  end

  typedef struct {
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        exp_men;
    logic        exp_mwe;
    logic [29:0] exp_maddr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [8];
  vec_t        v;
  logic [33:0] exp_q[$];
  logic [33:0] exp_e;
  logic        got;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'd0; c_wdata = 32'd0;
    l_req = 1'b0; l_we = 1'b0; l_addr = 32'd0; l_wdata = 32'd0;
  endtask

  task automatic drive(input logic who, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (who) begin
      l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
    end
  endtask

  task automatic scramble(input logic who);
    if (who) begin
      l_we = 1'($urandom_range(0, 1)); l_addr = $urandom; l_wdata = $urandom;
    end else begin
      c_we = 1'($urandom_range(0, 1)); c_addr = $urandom; c_wdata = $urandom;
    end
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    reset = 1'b1;
    c_req = 1'b1;
    @(negedge clk);
    check("rst_outputs_during", 160'(all_out), 160'(0));
    check("rst_stall_follows_req", 160'(core_stall), 160'(1));
    tick();
    c_req = 1'b0;
    @(negedge clk);
    check("rst_outputs_held", 160'(all_out), 160'(0));
    check("rst_stall_low", 160'(core_stall), 160'(0));
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    //          who   we    addr          wdata         err   men   mwe   maddr    rdata
    vecs[0] = '{1'b0, 1'b0, 32'h00000010, 32'h00000000, 1'b0, 1'b1, 1'b0, 30'h04, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h00000100, 32'h12345678, 1'b0, 1'b1, 1'b1, 30'h40, 32'h00000000};
    vecs[2] = '{1'b0, 1'b0, 32'h00000100, 32'h00000055, 1'b0, 1'b1, 1'b0, 30'h40, 32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 32'h00000013, 32'h00000066, 1'b1, 1'b0, 1'b0, 30'h04, 32'h00000000};
    vecs[4] = '{1'b1, 1'b1, 32'h00000202, 32'hAAAA5555, 1'b1, 1'b0, 1'b0, 30'h80, 32'h00000000};
    vecs[5] = '{1'b1, 1'b0, 32'h00000200, 32'h00000077, 1'b0, 1'b1, 1'b0, 30'h80, 32'hDEADBCFF};
    vecs[6] = '{1'b0, 1'b1, 32'h00000010, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 30'h04, 32'h00000000};
    vecs[7] = '{1'b1, 1'b0, 32'h00000010, 32'h00000088, 1'b0, 1'b1, 1'b0, 30'h04, 32'hCAFEF00D};

    do_reset();

    // Single-requester transactions through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      tick();
      idle_inputs();
      drive(v.who, v.we, v.addr, v.wdata);
      exp_q.push_back({v.who, v.exp_err, v.exp_rdata});
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin
        @(negedge clk);
        check($sformatf("v%0d_stall_k%0d", i, k), 160'(core_stall), 160'(!v.who && k < 2));
        if (k == 0) check($sformatf("v%0d_idle", i), 160'({c_gnt, l_gnt, m_en, m_we}), 160'(0));
        if (k == 1) begin
          check($sformatf("v%0d_m_en", i), 160'(m_en), 160'(v.exp_men));
          check($sformatf("v%0d_m_we", i), 160'(m_we), 160'(v.exp_mwe));
          check($sformatf("v%0d_m_addr", i), 160'(m_addr), 160'(v.exp_maddr));
          check($sformatf("v%0d_m_wdata", i), 160'(m_wdata), 160'(v.wdata));
          check($sformatf("v%0d_gnt", i), 160'({l_gnt, c_gnt}), 160'(v.who ? 2'b10 : 2'b01));
        end
        if (c_ready || l_ready) begin
          got = 1'b1;
          check($sformatf("v%0d_latency", i), 160'(k), 160'(2));
          check($sformatf("v%0d_one_ready", i), 160'(c_ready & l_ready), 160'(0));
          exp_e = exp_q.pop_front();
          check($sformatf("v%0d_resp", i),
                160'({l_ready, l_ready ? l_err : c_err, l_ready ? l_rdata : c_rdata}),
                160'(exp_e));
          check($sformatf("v%0d_loser_zero", i),
                160'(v.who ? {c_ready, c_err, c_gnt, c_rdata} : {l_ready, l_err, l_gnt, l_rdata}),
                160'(0));
          check($sformatf("v%0d_resp_m_en", i), 160'(m_en), 160'(0));
        end else begin
          tick();
          if (k == 0) scramble(v.who);
        end
      end
      check($sformatf("v%0d_ready_seen", i), 160'(got), 160'(1));
    end
    check("sb_empty", 160'(exp_q.size()), 160'(0));

    // Tie after reset: core first, then loader, then core again.
    do_reset();
    tick();
    idle_inputs();
    drive(1'b0, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b0, 32'h100, 32'h0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("tie_c_ready_k%0d", k), 160'(c_ready), 160'(k == 2 || k == 8));
      check($sformatf("tie_l_ready_k%0d", k), 160'(l_ready), 160'(k == 5));
      check($sformatf("tie_gnt_excl_k%0d", k), 160'(c_gnt & l_gnt), 160'(0));
      if (k == 5) check("tie_l_rdata", 160'(l_rdata), 160'(32'h12345678));
      tick();
    end
    idle_inputs();

    // Reset while in ACCESS abandons the access; the held request is served afresh.
    tick();
    drive(1'b0, 1'b0, 32'h10, 32'h0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rstacc_outputs_in_reset", 160'(all_out), 160'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstacc_outputs_after", 160'(all_out), 160'(0));
    check("rstacc_stall", 160'(core_stall), 160'(1));
    tick();
    @(negedge clk);
    check("rstacc_retry_m_en", 160'({m_en, m_addr}), 160'({1'b1, 30'h4}));
    check("rstacc_no_ready", 160'(c_ready), 160'(0));
    tick();
    @(negedge clk);
    check("rstacc_retry_ready", 160'({c_ready, c_err, c_rdata}), 160'({2'b10, 32'hCAFEF00D}));
    tick();
    idle_inputs();

    // Request dropped during ACCESS still completes, and only once.
    tick();
    drive(1'b0, 1'b0, 32'h10, 32'h0);
    tick();
    c_req = 1'b0;
    @(negedge clk);
    check("drop_m_en", 160'(m_en), 160'(1));
    tick();
    @(negedge clk);
    check("drop_ready", 160'({c_ready, c_rdata}), 160'({1'b1, 32'hCAFEF00D}));
    check("drop_stall", 160'(core_stall), 160'(0));
    for (int k = 3; k < 6; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("drop_quiet_k%0d", k), 160'({c_ready, m_en, c_gnt}), 160'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have the ports below, one per line: name  direction  width  meaning.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 c_req, c_we  input  1 each  core data-port request; write enable.
REQ-005 c_addr, c_wdata  input  32 each  core byte address; core write data.
REQ-006 c_rdata  output  32  core read data, valid only while c_ready=1.
REQ-007 c_ready, c_err  output  1 each  core completion pulse; misalign error flag.
REQ-008 c_gnt  output  1  core owns the memory port.
REQ-009 l_req, l_we, l_addr, l_wdata, l_rdata, l_ready, l_err, l_gnt  same directions/widths as core set  program-loader requester.
REQ-010 core_stall  output  1  freezes core PC/regwrite; equals c_req AND NOT c_ready.
REQ-011 m_en, m_we  output  1 each  memory enable; memory write enable.
REQ-012 m_addr  output  30  word address, the winner's addr[31:2].
REQ-013 m_wdata  output  32  memory write data.
REQ-014 m_rdata  input  32  memory read data; synchronous, valid one cycle after m_en.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, RESP; one access in flight at most.
REQ-016 IDLE: if any req=1, select winner, latch winner id, we, addr, wdata; next ACCESS; else stay IDLE.
REQ-017 Selection: sole requester wins; if both request, the requester not in last_grant wins (round-robin).
REQ-018 ACCESS: m_en=1 unless latched addr[1:0]!=0; m_we=latched we; m_addr/m_wdata from latched values; next RESP.
REQ-019 RESP: winner's ready=1 for exactly one cycle; rdata=m_rdata on aligned read, 0 on write or error; err=1 iff misaligned; last_grant<=winner; next IDLE.
REQ-020 Misaligned access SHALL never assert m_en or m_we.
REQ-021 Winner's gnt SHALL be 1 in ACCESS and RESP, 0 otherwise; never both gnt high.
REQ-022 Latency: req sampled in IDLE at cycle N -> ready at cycle N+2; peak throughput one access per 3 cycles.
REQ-023 Requesters SHALL hold req and fields until ready; values changed after the IDLE sample are ignored (latched copy used).
REQ-024 Req dropped while in ACCESS/RESP: access still completes and ready still pulses.
REQ-025 Req held high after ready: re-arbitrated in the following IDLE cycle as a new access.
REQ-026 Loser's req is not queued separately; it is served in the next IDLE arbitration.
REQ-027 All outputs except core_stall SHALL be functions of registered state only, with no combinational req-to-output path.
REQ-028 Non-winner's ready, err, rdata, gnt SHALL be 0.

Reset
REQ-029 reset=1 on a clock edge SHALL force state IDLE; last_grant=loader (core wins first tie); latched registers 0.
REQ-030 During and after reset, every output SHALL be 0 except core_stall, which follows c_req.
REQ-031 Reset in ACCESS or RESP SHALL abandon the access: no ready pulse, m_en=0 from the next cycle.

Verification
REQ-032 Core read alone: c_req=1, c_we=0, c_addr=0x10, m_rdata=0xDEADBEEF -> m_en=1, m_addr=0x4 at N+1; c_ready=1, c_rdata=0xDEADBEEF at N+2; core_stall=1 at N and N+1.
REQ-033 Tie after reset: c_req and l_req both held -> core served first (c_ready at N+2), loader next (l_ready at N+5), then core again (N+8).
REQ-034 Loader write: l_we=1, l_addr=0x100, l_wdata=0x12345678 -> m_we=1, m_addr=0x40, m_wdata=0x12345678 for one cycle; l_ready pulse with l_rdata=0.
REQ-035 Misaligned: c_addr=0x13 -> m_en stays 0; c_ready=1 and c_err=1 at N+2; c_rdata=0.
REQ-036 Reset in ACCESS: assert reset at N+1 -> no c_ready, all outputs 0 at N+2; after release, the held request is served as new.
REQ-037 Req dropped in ACCESS: c_req falls at N+1 -> c_ready still pulses at N+2; no second access.
